alu_divider: RTL

Iterative multi-cycle integer divider for the DecodeExecute stage. It is the inverse operation to the ALU adder path: one restoring subtract-and-shift step per clock. It produces quotient and remainder for signed or unsigned N-bit operands. Valid/ready handshakes on both sides let the execute stage stall while a division is in flight.

---
 rtl/alu_defs.sv | 28 ++
 rtl/full_adder.sv | 21 ++
 rtl/n_bit_subtractor.sv | 38 +++
 rtl/alu_divider.sv | 148 ++++++++++++++
 4 files changed

// File: rtl/alu_defs.sv
// ============================================================================
// Module : alu_defs
// Brief  : Shared divider state encodings, fill constant and M-extension opcodes.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package alu_defs;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FIXUP = 2'd2,
        DONE  = 2'd3
    } div_state_t;

    // Quotient on divide-by-zero is every bit set; replicated to the operand width.
    localparam logic DIVZ_FILL = 1'b1;

    // funct3 encodings the decode stage uses to select a divider operation.
    localparam logic [2:0] OP_DIV  = 3'b100;
    localparam logic [2:0] OP_DIVU = 3'b101;
    localparam logic [2:0] OP_REM  = 3'b110;
    localparam logic [2:0] OP_REMU = 3'b111;

endpackage

`default_nettype wire

// File: rtl/full_adder.sv
// ============================================================================
// Module : full_adder
// Brief  : Single-bit full adder cell for the trial subtractor chain.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module full_adder (
    input  logic a_i,
    input  logic b_i,
    input  logic cin_i,
    output logic sum_o,
    output logic cout_o
);

    assign sum_o  = a_i ^ b_i ^ cin_i;
    assign cout_o = (a_i & b_i) | (cin_i & (a_i ^ b_i));

endmodule

`default_nettype wire

// File: rtl/n_bit_subtractor.sv
// ============================================================================
// Module : n_bit_subtractor
// Brief  : Ripple subtractor a - b from full adders with b inverted and cin=1.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module n_bit_subtractor #(
    parameter int N = 33
) (
    input  logic [N-1:0] a_i,
    input  logic [N-1:0] b_i,
    output logic [N-1:0] diff_o,
    output logic         borrow_n_o
);

    logic [N:0] w_carry;

    assign w_carry[0] = 1'b1;

    generate
        for (genvar i = 0; i < N; i++) begin : g_chain
            full_adder u_fa (
                .a_i    (a_i[i]),
                .b_i    (~b_i[i]),
                .cin_i  (w_carry[i]),
                .sum_o  (diff_o[i]),
                .cout_o (w_carry[i+1])
            );
        end
    endgenerate

    // A missing final carry means a < b: the trial went negative.
    assign borrow_n_o = ~w_carry[N];

endmodule

`default_nettype wire

// File: rtl/alu_divider.sv
// ============================================================================
// Module : alu_divider
// Brief  : Iterative restoring divider, one quotient bit per clock, signed/unsigned.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_divider
    import alu_defs::*;
#(
    parameter int N = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start_valid,
    output logic         start_ready,
    input  logic [N-1:0] dividend,
    input  logic [N-1:0] divisor,
    input  logic         is_signed,
    output logic         result_valid,
    input  logic         result_ready,
    output logic [N-1:0] quotient,
    output logic [N-1:0] remainder,
    output logic         div_by_zero
);

    localparam int            CW   = $clog2(N + 1);
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    div_state_t    state_q, state_d;
    logic [N-1:0]  rem_q, rem_d;
    logic [N-1:0]  quo_q, quo_d;
    logic [N-1:0]  dvs_q, dvs_d;
    logic [N-1:0]  quotient_q, quotient_d;
    logic [N-1:0]  remainder_q, remainder_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          neg_quo_q, neg_quo_d;
    logic          neg_rem_q, neg_rem_d;
    logic          dbz_q, dbz_d;

    logic          w_a_neg, w_b_neg;
    logic [N:0]    w_shift, w_trial;
    logic          w_borrow;
    logic          w_unused_trial_msb;

    assign w_a_neg = is_signed & dividend[N-1];
    assign w_b_neg = is_signed & divisor[N-1];
    assign w_shift = {rem_q, quo_q[N-1]};

    n_bit_subtractor #(.N(N + 1)) u_sub (
        .a_i        (w_shift),
        .b_i        ({1'b0, dvs_q}),
        .diff_o     (w_trial),
        .borrow_n_o (w_borrow)
    );

    // On commit the trial is below the divisor, so its top bit is always zero.
    assign w_unused_trial_msb = w_trial[N];

    always_comb begin
        state_d     = state_q;
        rem_d       = rem_q;
        quo_d       = quo_q;
        dvs_d       = dvs_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        cnt_d       = cnt_q;
        neg_quo_d   = neg_quo_q;
        neg_rem_d   = neg_rem_q;
        dbz_d       = dbz_q;
        case (state_q)
            IDLE: begin
                if (start_valid) begin
                    neg_quo_d = w_a_neg ^ w_b_neg;
                    neg_rem_d = w_a_neg;
                    if (divisor == '0) begin
                        quotient_d  = {N{DIVZ_FILL}};
                        remainder_d = dividend;
                        dbz_d       = 1'b1;
                        state_d     = DONE;
                    end else begin
                        quo_d   = w_a_neg ? -dividend : dividend;
                        dvs_d   = w_b_neg ? -divisor : divisor;
                        rem_d   = '0;
                        cnt_d   = '0;
                        state_d = RUN;
                    end
                end
            end
            RUN: begin
                quo_d = {quo_q[N-2:0], ~w_borrow};
                rem_d = w_borrow ? w_shift[N-1:0] : w_trial[N-1:0];
                if (cnt_q == LAST) begin
                    state_d = FIXUP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            FIXUP: begin
                quotient_d  = neg_quo_q ? -quo_q : quo_q;
                remainder_d = neg_rem_q ? -rem_q : rem_q;
                dbz_d       = 1'b0;
                state_d     = DONE;
            end
            DONE: begin
                if (result_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            rem_q       <= '0;
            quo_q       <= '0;
            dvs_q       <= '0;
            quotient_q  <= '0;
            remainder_q <= '0;
            cnt_q       <= '0;
            neg_quo_q   <= 1'b0;
            neg_rem_q   <= 1'b0;
            dbz_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            rem_q       <= rem_d;
            quo_q       <= quo_d;
            dvs_q       <= dvs_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            cnt_q       <= cnt_d;
            neg_quo_q   <= neg_quo_d;
            neg_rem_q   <= neg_rem_d;
            dbz_q       <= dbz_d;
        end
    end

    assign start_ready  = (state_q == IDLE);
    assign result_valid = (state_q == DONE);
    assign quotient     = quotient_q;
    assign remainder    = remainder_q;
    assign div_by_zero  = dbz_q;

endmodule

`default_nettype wire
